// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner: synchronise, debounce, edge-detect and
// latch a request until acknowledged, then hold off re-requests for a lockout window.
module ped_request_conditioner #(
  parameter int unsigned FPGAFREQ      = 50_000_000,
  parameter int unsigned T_DEBOUNCE_MS = 20,
  parameter int unsigned T_LOCKOUT     = 2,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic b_raw,
  input  logic ack,
  output logic btn_level,
  output logic req_pulse,
  output logic req,
  output logic sol_light,
  output logic busy
);

  localparam int unsigned DB_RAW    = FPGAFREQ * T_DEBOUNCE_MS / 1000;
  localparam int unsigned DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int unsigned DB_W      = $clog2(DB_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  localparam int unsigned LK_CYCLES = FPGAFREQ * T_LOCKOUT;
  localparam int unsigned LK_W      = $clog2(LK_CYCLES) + 1;
  localparam logic [LK_W-1:0] LK_LOAD = (LK_CYCLES > 0) ? LK_W'(LK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, PENDING, LOCKOUT} state_t;

  // Normalised before the synchroniser so its reset value is the released level.
  logic b_norm;
  assign b_norm = b_raw ^ ACTIVE_LOW;

  logic            sync1_q, sync2_q;
  logic            btn_level_q, btn_level_d;
  logic            btn_prev_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      btn_level_q <= 1'b0;
      btn_prev_q  <= 1'b0;
      db_cnt_q    <= '0;
    end else begin
      sync1_q     <= b_norm;
      sync2_q     <= sync1_q;
      btn_level_q <= btn_level_d;
      btn_prev_q  <= btn_level_q;
      db_cnt_q    <= db_cnt_d;
    end
  end

  always_comb begin
    db_cnt_d    = '0;
    btn_level_d = btn_level_q;
    if (sync2_q != btn_level_q) begin
      if (db_cnt_q == DB_MAX) begin
        btn_level_d = ~btn_level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign press = btn_level_q & ~btn_prev_q;

  state_t          state_q, state_d;
  logic [LK_W-1:0] lk_cnt_q, lk_cnt_d;
  logic            req_pulse_q, req_pulse_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lk_cnt_q    <= '0;
      req_pulse_q <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lk_cnt_q    <= lk_cnt_d;
      req_pulse_q <= req_pulse_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
    end
  end

  // ack takes priority over a coincident press; presses outside IDLE are dropped.
  always_comb begin
    state_d  = state_q;
    lk_cnt_d = lk_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (press) state_d = PENDING;
      end
      PENDING: begin
        if (ack) begin
          if (LK_CYCLES > 0) begin
            state_d  = LOCKOUT;
            lk_cnt_d = LK_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOCKOUT: begin
        if (lk_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          lk_cnt_d = lk_cnt_q - LK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_pulse_d = (state_q == IDLE) && press;
    req_d       = (state_d == PENDING);
    busy_d      = (state_d == LOCKOUT);
  end

  assign btn_level = btn_level_q;
  assign req_pulse = req_pulse_q;
  assign req       = req_q;
  assign sol_light = req_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Directed bench for ped_request_conditioner: debounce latency, bounce rejection,
// ack/lockout timing, ack-vs-press priority, expiry-edge press and mid-lockout reset.
module tb_ped_request_conditioner;

  logic clk, reset, b_raw, ack;
  logic btn_level, req_pulse, req, sol_light, busy;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic acc;

  ped_request_conditioner #(
    .FPGAFREQ     (1000),
    .T_DEBOUNCE_MS(4),
    .T_LOCKOUT    (1),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .b_raw    (b_raw),
    .ack      (ack),
    .btn_level(btn_level),
    .req_pulse(req_pulse),
    .req      (req),
    .sol_light(sol_light),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press at E0 (next edge): btn_level at E5, req/req_pulse at E6, pulse gone at E7.
  task automatic press_check(input string tag);
    b_raw = 1'b0;
    repeat (5) tick();
    check({tag, "_lvl_E4"}, btn_level, 1'b0);
    tick();
    check({tag, "_lvl_E5"}, btn_level, 1'b1);
    check({tag, "_req_E5"}, req, 1'b0);
    tick();
    check({tag, "_req_E6"}, req, 1'b1);
    check({tag, "_pulse_E6"}, req_pulse, 1'b1);
    check({tag, "_sol_E6"}, sol_light, 1'b1);
    tick();
    check({tag, "_pulse_E7"}, req_pulse, 1'b0);
    check({tag, "_req_E7"}, req, 1'b1);
  endtask

  task automatic release_wait();
    b_raw = 1'b1;
    repeat (10) tick();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    b_raw = 1'b1;
    ack   = 1'b0;
    reset = 1'b1;

    // Reset with the button physically pressed
    b_raw = 1'b0;
    repeat (3) tick();
    check("rst_btn_level", btn_level, 1'b0);
    check("rst_req_pulse", req_pulse, 1'b0);
    check("rst_req", req, 1'b0);
    check("rst_sol", sol_light, 1'b0);
    check("rst_busy", busy, 1'b0);
    b_raw = 1'b1;
    reset = 1'b0;
    acc = 1'b0;
    repeat (50) begin
      tick();
      acc = acc | btn_level | req_pulse | req | sol_light | busy;
    end
    check("idle_50_quiet", acc, 1'b0);

    // Bounce: 3-cycle runs never reach the debounce threshold
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) b_raw = ~b_raw;
      tick();
      acc = acc | btn_level | req | req_pulse;
    end
    b_raw = 1'b1;
    repeat (10) begin
      tick();
      acc = acc | btn_level | req | req_pulse;
    end
    check("bounce_rejected", acc, 1'b0);

    // Clean press, then release leaves the request latched
    press_check("press1");
    release_wait();
    check("release_lvl", btn_level, 1'b0);
    check("release_keeps_req", req, 1'b1);

    // Ack and full lockout with a press inside it
    pulse_ack();
    check("ack_req", req, 1'b0);
    check("ack_sol", sol_light, 1'b0);
    check("ack_busy", busy, 1'b1);
    acc = 1'b0;
    for (int k = 1; k <= 999; k++) begin
      if (k == 100) b_raw = 1'b0;
      if (k == 200) b_raw = 1'b1;
      tick();
      if (k == 110) check("lock_press_lvl", btn_level, 1'b1);
      acc = acc | req_pulse | req;
    end
    check("lock_busy_999", busy, 1'b1);
    check("lock_press_ignored", acc, 1'b0);
    tick();
    check("lock_busy_1000", busy, 1'b0);
    press_check("press2");

    // Second press edge coincides with ack: ack wins
    release_wait();
    b_raw = 1'b0;
    repeat (6) tick();
    check("sim_lvl_E5", btn_level, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("sim_req", req, 1'b0);
    check("sim_busy", busy, 1'b1);
    check("sim_pulse", req_pulse, 1'b0);
    acc = 1'b0;
    repeat (999) begin
      tick();
      acc = acc | req_pulse | req;
    end
    tick();
    check("sim_busy_1000", busy, 1'b0);
    repeat (20) begin
      tick();
      acc = acc | req_pulse | req;
    end
    check("held_no_retrigger", acc, 1'b0);

    // Press edge landing in the expiry cycle is dropped
    release_wait();
    press_check("press3");
    release_wait();
    pulse_ack();
    repeat (993) tick();
    b_raw = 1'b0;
    repeat (7) tick();
    check("exp_busy", busy, 1'b0);
    check("exp_req", req, 1'b0);
    tick();
    check("exp_pulse_next", req_pulse, 1'b0);
    check("exp_req_next", req, 1'b0);
    repeat (10) tick();
    check("exp_req_later", req, 1'b0);
    check("exp_lvl_held", btn_level, 1'b1);

    // Reset in the middle of lockout
    release_wait();
    press_check("press4");
    release_wait();
    pulse_ack();
    repeat (300) tick();
    check("mid_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_req", req, 1'b0);
    check("mid_rst_sol", sol_light, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", busy, 1'b0);
    press_check("press_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ped_request_conditioner.md
# ped_request_conditioner

Upstream conditioner for the pedestrian push-button of the traffic-light controller. It synchronizes and debounces the raw button and turns each accepted press into a latched request. The request is held until the controller acknowledges service, followed by a lockout window that blocks immediate re-requests. Its `req` output replaces the raw button input of the controller, and its `sol_light` output drives the "request pending" LED.

## Interface

Parameters:

- `FPGAFREQ`, default 50_000_000: clock frequency in Hz.
- `T_DEBOUNCE_MS`, default 20: debounce stability window in ms. The window is DB_CYCLES = FPGAFREQ*T_DEBOUNCE_MS/1000 cycles, clamped to a minimum of 1.
- `T_LOCKOUT`, default 2: seconds after `ack` during which presses are ignored. A value of 0 means no lockout.
- `ACTIVE_LOW`, default 1: `b_raw` polarity. 1 means pressed = 0.

Ports:

- `clk`, input, 1 bit: clock.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `b_raw`, input, 1 bit: raw, asynchronous, bouncing button.
- `ack`, input, 1 bit: one-cycle pulse from the controller when the pedestrian phase is granted.
- `btn_level`, output, 1 bit: debounced button level, 1 = pressed.
- `req_pulse`, output, 1 bit: one-cycle strobe on each accepted press.
- `req`, output, 1 bit: latched pedestrian request. Held high until `ack`.
- `sol_light`, output, 1 bit: request LED. High while `req` is high.
- `busy`, output, 1 bit: high in the LOCKOUT state.

## Operation

- **Polarity:** `b_raw` is normalised internally to pressed = 1 according to `ACTIVE_LOW`.
- **Synchronizer:** two flip-flops in series, sync1 then sync2.
- **Debouncer:**
  - A counter `db_cnt` holds width $clog2(DB_CYCLES)+1.
  - Each cycle with sync2 ≠ `btn_level`, `db_cnt` increments.
  - Any cycle with sync2 == `btn_level` clears `db_cnt` to 0.
  - When a mismatch occurs with `db_cnt` == DB_CYCLES-1, `btn_level` toggles and `db_cnt` clears.
  - Glitches shorter than DB_CYCLES cycles never reach `btn_level`.
- **Edge detect:** `btn_level` is registered. `press` = `btn_level` & ~`btn_level_d` (rising edge only). Releases produce nothing.
- **FSM states:** IDLE, PENDING, LOCKOUT.
  - IDLE: on `press`, go to PENDING, and assert `req_pulse` for 1 cycle.
  - PENDING: `req` = 1. On `ack`: if T_LOCKOUT > 0, go to LOCKOUT and load `lk_cnt` = FPGAFREQ*T_LOCKOUT-1; otherwise go to IDLE. Presses in this state are absorbed (no `req_pulse`).
  - LOCKOUT: `req` = 0, `busy` = 1. `lk_cnt` decrements each cycle. At `lk_cnt` == 0, go to IDLE. Presses are ignored and not remembered.
  - `lk_cnt` width is $clog2(FPGAFREQ*T_LOCKOUT)+1. It never wraps; the FSM leaves LOCKOUT at 0.
- **Outputs:** `req` and `busy` are registered state decodes. `sol_light` = `req`.
- **Boundary cases:**
  - `ack` in IDLE or LOCKOUT is ignored.
  - `press` and `ack` in the same cycle in PENDING: `ack` wins. The FSM goes to LOCKOUT (or IDLE) and the press is dropped.
  - `press` in the cycle LOCKOUT expires is dropped. A button still held after expiry does not re-trigger; a new rising edge is required.
  - Reset mid-debounce or mid-lockout aborts everything and returns to the reset values.

## Timing

- **Reset values:**
  - sync1 and sync2 = released level.
  - `btn_level` = 0, `btn_level_d` = 0.
  - `db_cnt` = 0, `lk_cnt` = 0.
  - State = IDLE.
  - `req` = 0, `req_pulse` = 0, `sol_light` = 0, `busy` = 0.
- **Press latency:** `b_raw` settles pressed before clock edge E0.
  - sync2 valid after E1.
  - `btn_level` rises at E(DB_CYCLES+1).
  - `req_pulse` and `req` rise at E(DB_CYCLES+2).
- **Release:** `btn_level` falls DB_CYCLES+1 edges after a stable release. Release has no effect on `req`.
- **Ack:** `ack` sampled at edge A.
  - `req` and `sol_light` fall at A.
  - `busy` rises at A.
  - `busy` falls at A + FPGAFREQ*T_LOCKOUT.
  - The earliest new `req_pulse` is one edge after that.
- **Pulse width:** `req_pulse` is exactly 1 cycle wide and occurs at most once per PENDING entry.

## Test plan

Bench parameters: FPGAFREQ=1000, T_DEBOUNCE_MS=4 (DB_CYCLES=4), T_LOCKOUT=1 (1000-cycle lockout), ACTIVE_LOW=1.

1. **Reset:** hold `reset` high, drive `b_raw`=0 → all outputs 0. Release reset with `b_raw`=1 → outputs stay 0 for 50 cycles.
2. **Clean press:** drive `b_raw` 1→0 before E0 and hold → `btn_level`=1 at E5; `req_pulse`=1 only at E6; `req`=`sol_light`=1 from E6.
3. **Bounce rejection:** toggle `b_raw` 0/1 every 3 cycles for 40 cycles, then hold at 1 → `btn_level`, `req`, `req_pulse` stay 0.
4. **Ack and lockout:** with `req`=1, pulse `ack` at edge A → `req`=0 and `busy`=1 at A; a press during lockout gives no `req_pulse`; `busy`=0 at A+1000; a fresh press afterwards sets `req` again after 6 edges.
5. **Simultaneous press and ack:** in PENDING, align a second press edge with the `ack` cycle → FSM enters LOCKOUT, `req`=0, no `req_pulse`. A held button after lockout expiry does not re-trigger.
6. **Reset mid-lockout:** assert `reset` at A+300 → `busy`=0 and state IDLE immediately. After release, a press is accepted with the normal 6-edge latency.
